// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: elastic FIFO between instruction fetch and decode.
// Words are captured with a valid/ready handshake and presented to decode
// one cycle later (no fall-through). FlushD discards every entry.
// Optional macro FDB_BUBBLE_NOP_EN: while empty, InstrD shows the canonical
// NOP (addi x0,x0,0) instead of all zeros.
module fetch_decode_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int ILEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ILEN-1:0]          InstrF,
  input  logic [XLEN-1:0]          PCF,
  input  logic                     ValidF,
  output logic                     ReadyF,
  output logic [ILEN-1:0]          InstrD,
  output logic [24:0]              ImmD,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  output logic                     ValidD,
  input  logic                     ReadyD,
  input  logic                     FlushD,
  output logic [$clog2(DEPTH):0]   CountD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef FDB_BUBBLE_NOP_EN
  localparam logic [ILEN-1:0] BUBBLE = ILEN'(32'h0000_0013);
`else
  localparam logic [ILEN-1:0] BUBBLE = '0;
`endif

  logic [ILEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push;
  logic          pop;

  // Handshakes derive only from registered occupancy and FlushD, so ReadyF
  // never depends combinationally on ReadyD.
  always_comb begin
    ValidD = (count_q != '0);
    ReadyF = (count_q != FULL_CNT) & ~FlushD;
    push   = ValidF & ReadyF;
    pop    = ValidD & ReadyD;
    CountD = count_q;
  end

  // Next occupancy and pointers; flush wins over any concurrent push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FlushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: cleared asynchronously, so entries vanish at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= InstrF;
      pc_mem_q[wr_ptr_q]    <= PCF;
    end
  end

  // Head entry to decode, masked to a bubble/zero PC while empty.
  always_comb begin
    InstrD   = ValidD ? instr_mem_q[rd_ptr_q] : BUBBLE;
    PCD      = ValidD ? pc_mem_q[rd_ptr_q]    : '0;
    PCPlus4D = PCD + XLEN'(4);
    ImmD     = InstrD[31:7];
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: stimulus queues expected words,
// a negedge monitor pops and compares whenever decode consumes the head.
module tb_fetch_decode_buffer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int ILEN  = 32;

`ifdef FDB_BUBBLE_NOP_EN
  localparam logic [31:0] EXP_BUBBLE = 32'h0000_0013;
`else
  localparam logic [31:0] EXP_BUBBLE = 32'h0000_0000;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ILEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic            ValidF;
  logic            ReadyF;
  logic [ILEN-1:0] InstrD;
  logic [24:0]     ImmD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic            ReadyD;
  logic            FlushD;
  logic [1:0]      CountD;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ILEN(ILEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .InstrF(InstrF), .PCF(PCF), .ValidF(ValidF), .ReadyF(ReadyF),
    .InstrD(InstrD), .ImmD(ImmD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .ReadyD(ReadyD), .FlushD(FlushD), .CountD(CountD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest outstanding word.
  always @(negedge clk) begin
    if (rst_n && ValidD && ReadyD && !FlushD) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got PCD 0x%0h expected no entry", PCD);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("pop_instr",  64'(InstrD),   64'(e.instr));
        chk("pop_pc",     PCD,           e.pc);
        chk("pop_pc4",    PCPlus4D,      e.pc + 64'd4);
        chk("pop_imm",    64'(ImmD),     64'(e.instr[31:7]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for one cycle; acc is the hand-derived acceptance.
  task automatic send(input logic [31:0] i, input logic [63:0] p, input logic acc, input string nm);
    InstrF = i;
    PCF    = p;
    ValidF = 1'b1;
    #2;
    chk(nm, 64'(ReadyF), 64'(acc));
    if (acc) exp_q.push_back('{instr: i, pc: p});
    step();
    ValidF = 1'b0;
  endtask

  // Flush with a concurrent word offered; nothing may be captured.
  task automatic flush_with(input logic [31:0] i, input logic [63:0] p);
    InstrF = i;
    PCF    = p;
    ValidF = 1'b1;
    FlushD = 1'b1;
    #2;
    chk("flush_readyf", 64'(ReadyF), 64'd0);
    step();
    FlushD = 1'b0;
    ValidF = 1'b0;
    exp_q.delete();
    chk("flush_count",  64'(CountD), 64'd0);
    chk("flush_validd", 64'(ValidD), 64'd0);
    chk("flush_bubble", 64'(InstrD), 64'(EXP_BUBBLE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    InstrF = '0;
    PCF    = '0;
    ValidF = 1'b0;
    ReadyD = 1'b0;
    FlushD = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / empty state
    chk("rst_validd", 64'(ValidD),  64'd0);
    chk("rst_readyf", 64'(ReadyF),  64'd1);
    chk("rst_count",  64'(CountD),  64'd0);
    chk("rst_instr",  64'(InstrD),  64'(EXP_BUBBLE));
    chk("rst_pc4",    PCPlus4D,     64'd4);

    // Asynchronous reset mid-cycle while holding two entries
    send(32'h0000_1111, 64'h200, 1'b1, "mr_push0");
    send(32'h0000_2222, 64'h204, 1'b1, "mr_push1");
    chk("mr_count_full", 64'(CountD), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_validd", 64'(ValidD), 64'd0);
    chk("mr_count",  64'(CountD), 64'd0);
    chk("mr_readyf", 64'(ReadyF), 64'd1);
    chk("mr_instr",  64'(InstrD), 64'(EXP_BUBBLE));
    chk("mr_pcd",    PCD,         64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single pass: ImmD = 0x00A00093[31:7] = 0x14001
    ReadyD = 1'b1;
    send(32'h00A0_0093, 64'h8000_0000, 1'b1, "sp_push");
    chk("sp_validd", 64'(ValidD),  64'd1);
    chk("sp_imm",    64'(ImmD),    64'h14001);
    chk("sp_pc4",    PCPlus4D,     64'h8000_0004);
    step();
    chk("sp_validd_after", 64'(ValidD), 64'd0);

    // Fill under stall; third word refused, then re-offered
    ReadyD = 1'b0;
    send(32'hAAAA_0001, 64'h100, 1'b1, "fill_push0");
    send(32'hAAAA_0002, 64'h104, 1'b1, "fill_push1");
    chk("fill_count", 64'(CountD), 64'd2);
    send(32'hAAAA_0003, 64'h108, 1'b0, "fill_refused");
    chk("fill_head_pc", PCD, 64'h100);
    ReadyD = 1'b1;
    send(32'hAAAA_0003, 64'h108, 1'b0, "fill_full_pop_refused");
    chk("fill_count_after_pop", 64'(CountD), 64'd1);
    send(32'hAAAA_0003, 64'h108, 1'b1, "fill_reoffer");
    chk("fill_count_conc", 64'(CountD), 64'd1);
    step();
    chk("fill_drained", 64'(ValidD), 64'd0);

    // Concurrent push/pop at occupancy 1 across pointer wrap
    ReadyD = 1'b0;
    send(32'hCCCC_0000, 64'h300, 1'b1, "cc_push0");
    ReadyD = 1'b1;
    send(32'hCCCC_0001, 64'h304, 1'b1, "cc_push1");
    chk("cc_count1", 64'(CountD), 64'd1);
    send(32'hCCCC_0002, 64'h308, 1'b1, "cc_push2");
    chk("cc_count2", 64'(CountD), 64'd1);
    chk("cc_head",   PCD,         64'h308);
    step();
    chk("cc_empty", 64'(CountD), 64'd0);

    // Flush while full with a word offered
    ReadyD = 1'b0;
    send(32'hF0F0_0000, 64'h400, 1'b1, "fl_push0");
    send(32'hF0F0_0001, 64'h404, 1'b1, "fl_push1");
    chk("fl_count_full", 64'(CountD), 64'd2);
    flush_with(32'hF0F0_0002, 64'h408);

    // Flush at occupancy 1 with pop and push both requested
    send(32'hF0F0_0010, 64'h410, 1'b1, "fl1_push");
    ReadyD = 1'b1;
    flush_with(32'hF0F0_0011, 64'h414);

    // Buffer operates normally after a flush
    send(32'h1234_5678, 64'h500, 1'b1, "post_flush_push");
    chk("post_flush_pc", PCD, 64'h500);

    // PC wrap at all-ones
    send(32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, "wrap_push");
    chk("wrap_pcd", PCD,      64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4", PCPlus4D, 64'h0);
    step();
    chk("wrap_empty", 64'(ValidD), 64'd0);

    // Every queued word must have been consumed
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
